// File: rtl/stream_prefetch_ctrl.sv
// Line prefetcher feeding the instruction stream buffer: fetches one 64-byte line as
// sixteen word requests on ibus and forwards the in-order responses with a done pulse.
module stream_prefetch_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int LINE_WORDS      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prefetch_start,
    input  logic [12:0] prefetch_line_addr,
    input  logic        prefetch_abort,
    output logic        prefetch_req,
    output logic [18:0] prefetch_addr,
    input  logic        prefetch_gnt,
    input  logic        mem_r_valid,
    input  logic [31:0] mem_r_data,
    output logic        prefetch_r_valid,
    output logic [31:0] prefetch_r_data,
    output logic        prefetch_busy,
    output logic        prefetch_done
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [4:0]    ALL_WORDS = 5'(LINE_WORDS);
    localparam logic [4:0]    LAST_WORD = 5'(LINE_WORDS - 1);
    localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] OUT_ONE   = OW'(1);

    logic [1:0]    state_q, state_d;
    logic [12:0]   line_q, line_d;
    logic [4:0]    issue_cnt_q, issue_cnt_d;
    logic [4:0]    resp_cnt_q, resp_cnt_d;
    logic [OW-1:0] out_q, out_d;
    logic          r_valid_q, r_valid_d;
    logic [31:0]   r_data_q, r_data_d;
    logic          done_q, done_d;

    logic active;
    logic req;
    logic fire;
    logic rsp;
    logic fwd;
    logic last;

    always_comb begin
        active = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        req    = (state_q == ST_ISSUE) && (issue_cnt_q < ALL_WORDS) &&
                 (out_q < MAX_OUT) && !prefetch_abort;
        fire   = req && prefetch_gnt;
        // A response with nothing outstanding is a bus error; ignore it rather than wrap.
        rsp    = mem_r_valid && (out_q != '0);
        fwd    = active && !prefetch_abort && rsp;
        last   = fwd && (resp_cnt_q == LAST_WORD);
    end

    always_comb begin
        out_d = out_q;
        case ({fire, rsp})
            2'b10:   out_d = out_q + OUT_ONE;
            2'b01:   out_d = out_q - OUT_ONE;
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        issue_cnt_d = issue_cnt_q + 5'(fire);
        resp_cnt_d  = resp_cnt_q + 5'(fwd);
        r_valid_d   = fwd;
        r_data_d    = fwd ? mem_r_data : r_data_q;
        done_d      = last;

        case (state_q)
            ST_IDLE: begin
                // Abort has priority so a start racing an icache sleep is dropped.
                if (prefetch_start && !prefetch_abort) begin
                    line_d      = prefetch_line_addr;
                    issue_cnt_d = '0;
                    resp_cnt_d  = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (prefetch_abort) begin
                    state_d = ST_FLUSH;
                end else if (last) begin
                    state_d = ST_IDLE;
                end else if (issue_cnt_d == ALL_WORDS) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (prefetch_abort) begin
                    state_d = ST_FLUSH;
                end else if (last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (out_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            out_q       <= '0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            issue_cnt_q <= issue_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            out_q       <= out_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            done_q      <= done_d;
        end
    end

    assign prefetch_req     = req;
    assign prefetch_addr    = {line_q, issue_cnt_q[3:0], 2'b00};
    assign prefetch_r_valid = r_valid_q;
    assign prefetch_r_data  = r_data_q;
    assign prefetch_busy    = (state_q != ST_IDLE);
    assign prefetch_done    = done_q;

    bus_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(mem_r_valid && (out_q == '0)));

endmodule

// File: tb/tb_stream_prefetch_ctrl.sv
// Bench for stream_prefetch_ctrl: random ibus responder plus a line-level reference
// model compared against the DUT on every negative clock edge.
module tb_stream_prefetch_ctrl;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prefetch_start = 1'b0;
    logic [12:0] prefetch_line_addr = '0;
    logic        prefetch_abort = 1'b0;
    logic        prefetch_req;
    logic [18:0] prefetch_addr;
    logic        prefetch_gnt = 1'b0;
    logic        mem_r_valid = 1'b0;
    logic [31:0] mem_r_data = '0;
    logic        prefetch_r_valid;
    logic [31:0] prefetch_r_data;
    logic        prefetch_busy;
    logic        prefetch_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    stream_prefetch_ctrl #(
        .MAX_OUTSTANDING(MAX_OUT),
        .LINE_WORDS     (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .prefetch_start    (prefetch_start),
        .prefetch_line_addr(prefetch_line_addr),
        .prefetch_abort    (prefetch_abort),
        .prefetch_req      (prefetch_req),
        .prefetch_addr     (prefetch_addr),
        .prefetch_gnt      (prefetch_gnt),
        .mem_r_valid       (mem_r_valid),
        .mem_r_data        (mem_r_data),
        .prefetch_r_valid  (prefetch_r_valid),
        .prefetch_r_data   (prefetch_r_data),
        .prefetch_busy     (prefetch_busy),
        .prefetch_done     (prefetch_done)
    );

    // Clock
    always #5 clk = ~clk;

    // Responder configuration and pending response times (in order)
    bit gnt_rand = 1'b0;
    bit hold_resp = 1'b0;
    int lat_min = 2;
    int lat_max = 2;
    int pend_q[$];

    // Reference model: a line is idle, fetching, or flushing
    bit          started = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_flush = 1'b0;
    logic [12:0] m_line = '0;
    int          m_issued = 0;
    int          m_returned = 0;
    int          m_out = 0;
    logic        e_rv = 1'b0;
    logic        e_done = 1'b0;
    logic [31:0] e_rdata = '0;

    // Observation logs used by the directed pins
    int          n_grant = 0;
    int          n_fwd = 0;
    int          n_done = 0;
    logic [18:0] addr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Memory side: grant policy and in-order read responses
    always @(posedge clk) begin
        #1;
        prefetch_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_r_data = $urandom;
        if (!hold_resp && pend_q.size() > 0 && pend_q[0] <= cyc) begin
            void'(pend_q.pop_front());
            mem_r_valid = 1'b1;
        end else begin
            mem_r_valid = 1'b0;
        end
    end

    // Compare, then advance the model by one clock
    always @(negedge clk) begin
        bit g;
        bit e_req;
        e_req = m_busy && !m_flush && (m_issued < 16) && (m_out < MAX_OUT) && !prefetch_abort;
        if (started) begin
            chk("busy", prefetch_busy, m_busy);
            chk("req", prefetch_req, e_req);
            if (e_req) chk("addr", prefetch_addr, {m_line, 4'(m_issued), 2'b00});
            chk("r_valid", prefetch_r_valid, e_rv);
            chk("r_data", prefetch_r_data, e_rdata);
            chk("done", prefetch_done, e_done);
            if (prefetch_r_valid === 1'b1) n_fwd++;
            if (prefetch_done === 1'b1) n_done++;
        end
        if (rst) begin
            started = 1'b1;
            m_busy = 1'b0;
            m_flush = 1'b0;
            m_line = '0;
            m_issued = 0;
            m_returned = 0;
            m_out = 0;
            e_rv = 1'b0;
            e_done = 1'b0;
            e_rdata = '0;
            pend_q.delete();
        end else begin
            g = e_req && prefetch_gnt;
            e_rv = 1'b0;
            e_done = 1'b0;
            if (g) begin
                pend_q.push_back(cyc + $urandom_range(lat_min, lat_max));
                n_grant++;
                addr_log.push_back(prefetch_addr);
            end
            if (!m_busy) begin
                if (prefetch_start && !prefetch_abort) begin
                    m_busy = 1'b1;
                    m_flush = 1'b0;
                    m_line = prefetch_line_addr;
                    m_issued = 0;
                    m_returned = 0;
                end
            end else if (m_flush) begin
                if (mem_r_valid && m_out > 0) m_out--;
                if (m_out == 0) begin
                    m_busy = 1'b0;
                    m_flush = 1'b0;
                end
            end else if (prefetch_abort) begin
                if (mem_r_valid && m_out > 0) m_out--;
                m_flush = 1'b1;
            end else begin
                if (g) begin
                    m_issued++;
                    m_out++;
                end
                if (mem_r_valid) begin
                    m_out--;
                    m_returned++;
                    e_rv = 1'b1;
                    e_rdata = mem_r_data;
                    if (m_returned == 16) begin
                        e_done = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input logic [12:0] a);
        prefetch_line_addr = a;
        prefetch_start = 1'b1;
        step();
        prefetch_start = 1'b0;
    endtask

    task automatic clear_logs();
        n_grant = 0;
        n_fwd = 0;
        n_done = 0;
        addr_log.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (prefetch_busy !== 1'b0 && n < 1000) begin
            step();
            n++;
        end
        chk({name, "_idle_in_time"}, 32'(n < 1000), 32'd1);
        step();
        step();
    endtask

    task automatic pin_idle_outputs(input string name);
        chk({name, "_req"}, prefetch_req, 32'd0);
        chk({name, "_addr"}, prefetch_addr, 32'd0);
        chk({name, "_busy"}, prefetch_busy, 32'd0);
        chk({name, "_r_valid"}, prefetch_r_valid, 32'd0);
        chk({name, "_r_data"}, prefetch_r_data, 32'd0);
        chk({name, "_done"}, prefetch_done, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) step();
        rst = 1'b0;
        pin_idle_outputs("reset");

        // Full line, grant always, fixed 2-cycle response latency
        clear_logs();
        start_line(13'h0042);
        wait_idle("line42");
        chk("line42_grants", n_grant, 16);
        chk("line42_first_addr", addr_log[0], 32'h01080);
        chk("line42_last_addr", addr_log[15], 32'h010BC);
        chk("line42_beats", n_fwd, 16);
        chk("line42_done", n_done, 1);

        // Responses withheld: outstanding limit caps grants, gnt stalls random
        clear_logs();
        hold_resp = 1'b1;
        gnt_rand = 1'b1;
        start_line(13'h0155);
        repeat (40) step();
        chk("hold_grants", n_grant, MAX_OUT);
        chk("hold_req_low", prefetch_req, 32'd0);
        hold_resp = 1'b0;
        wait_idle("hold");
        chk("hold_beats", n_fwd, 16);

        // Long latency: grant and response coincide around a full window
        clear_logs();
        gnt_rand = 1'b0;
        lat_min = 4;
        lat_max = 4;
        start_line(13'h0ABC);
        wait_idle("lat4");
        chk("lat4_beats", n_fwd, 16);
        chk("lat4_done", n_done, 1);

        // Abort after six grants with three outstanding
        clear_logs();
        lat_min = 3;
        lat_max = 3;
        start_line(13'h0300);
        n = 0;
        while (n_grant < 6 && n < 100) begin
            step();
            n++;
        end
        prefetch_abort = 1'b1;
        step();
        prefetch_abort = 1'b0;
        wait_idle("abort");
        chk("abort_grants", n_grant, 6);
        chk("abort_beats", n_fwd, 3);
        chk("abort_done", n_done, 0);

        // Starts while busy and while flushing are ignored
        clear_logs();
        hold_resp = 1'b1;
        lat_min = 1;
        lat_max = 3;
        start_line(13'h00AA);
        start_line(13'h00BB);
        step();
        prefetch_abort = 1'b1;
        step();
        prefetch_abort = 1'b0;
        start_line(13'h00CC);
        chk("flush_busy", prefetch_busy, 32'd1);
        hold_resp = 1'b0;
        wait_idle("flush");
        chk("busy_start_addr1", addr_log[1], 32'h02A84);
        chk("flush_done", n_done, 0);
        clear_logs();
        start_line(13'h00DD);
        wait_idle("after_flush");
        chk("after_flush_addr0", addr_log[0], 32'h03740);
        chk("after_flush_beats", n_fwd, 16);

        // Reset in the middle of ISSUE
        start_line(13'h0123);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pin_idle_outputs("midrst");
        step();
        clear_logs();
        start_line(13'h1FFF);
        wait_idle("post_rst");
        chk("post_rst_addr0", addr_log[0], 32'h7FFC0);
        chk("post_rst_beats", n_fwd, 16);
        chk("post_rst_done", n_done, 1);

        // Random traffic: grant stalls, latencies, aborts, stray starts, resets
        for (int it = 0; it < 40; it++) begin
            gnt_rand = 1'($urandom_range(0, 1));
            lat_min = 1;
            lat_max = $urandom_range(1, 6);
            start_line(13'($urandom));
            n = $urandom_range(5, 40);
            for (int k = 0; k < n; k++) begin
                prefetch_abort = ($urandom_range(0, 24) == 0);
                prefetch_start = ($urandom_range(0, 9) == 0);
                prefetch_line_addr = 13'($urandom);
                rst = ($urandom_range(0, 79) == 0);
                step();
            end
            prefetch_abort = 1'b0;
            prefetch_start = 1'b0;
            rst = 1'b0;
            wait_idle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_prefetch_ctrl.md
Name: stream_prefetch_ctrl

Overview:
- Upstream feeder of the instruction stream buffer: on a prefetch trigger it fetches one 64-byte line (16 x 32-bit words) from the instruction memory bus.
- Issues word requests with a req/gnt handshake and bounded outstanding requests.
- Forwards in-order read data to the stream buffer as a registered prefetch_r_valid/prefetch_r_data stream, with a completion pulse.
- Sits between the stream buffer FETCH_CHECK trigger and the ibus memory port.

Parameters:
- MAX_OUTSTANDING, 4, maximum granted-but-unreturned word requests (legal 1..16).
- LINE_WORDS, 16, words per line (fixed; address slicing assumes 16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- prefetch_start  in  1  one-cycle trigger to fetch a line
- prefetch_line_addr  in  13  line address (byte addr [18:6]), sampled with prefetch_start
- prefetch_abort  in  1  cancel the current line (e.g. icache sleep)
- prefetch_req  out  1  memory request
- prefetch_addr  out  19  byte address {line, word[3:0], 2'b00}
- prefetch_gnt  in  1  memory grant
- mem_r_valid  in  1  memory read response valid (in order, 1 per granted req)
- mem_r_data  in  32  memory read data
- prefetch_r_valid  out  1  word valid to stream buffer
- prefetch_r_data  out  32  word data to stream buffer
- prefetch_busy  out  1  high in any state except IDLE
- prefetch_done  out  1  one-cycle pulse when word 15 is forwarded

Behaviour:
- Single clock; synchronous active-high reset on clk. Reset values: state IDLE; all counters and line register 0; prefetch_req 0; prefetch_addr 0; prefetch_r_valid 0; prefetch_r_data 0; prefetch_busy 0; prefetch_done 0.
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - prefetch_start latches prefetch_line_addr, clears issue_cnt (5b) and resp_cnt (5b), then goes to ISSUE.
  - abort in IDLE is ignored; start and abort together in IDLE -> start ignored.
- ISSUE:
  - prefetch_req = (issue_cnt < 16) & (outstanding < MAX_OUTSTANDING) & ~prefetch_abort (combinational from registered state).
  - prefetch_addr = {line, issue_cnt[3:0], 2'b00}; held stable while req=1 and gnt=0.
  - req & gnt -> issue_cnt+1 and outstanding+1.
  - After the 16th grant (issue_cnt reaches 16) -> DRAIN.
- Outstanding counter ($clog2(MAX_OUTSTANDING+1) bits): +1 on req&gnt, -1 on mem_r_valid; both in the same cycle -> unchanged. mem_r_valid with outstanding==0 is a bus protocol error (assertion) and must not underflow.
- Forwarding (1-cycle latency):
  - In ISSUE/DRAIN: prefetch_r_valid <= mem_r_valid; prefetch_r_data <= mem_r_data when mem_r_valid, else held; resp_cnt+1 per response.
  - prefetch_r_data is zero only after reset.
- DRAIN: no requests. When the response with resp_cnt==15 arrives -> registered prefetch_done=1 in the same cycle as its prefetch_r_valid, then IDLE (prefetch_busy drops together with done).
- prefetch_start while busy is ignored (no queueing).
- Abort in ISSUE or DRAIN:
  - prefetch_req forced low that cycle; the ibus tolerates request withdrawal. Next state FLUSH.
  - A response arriving in the abort cycle is not forwarded.
- FLUSH: no requests; responses are consumed, not forwarded; outstanding==0 -> IDLE. prefetch_done never pulses for an aborted line.
- Abort and final response in the same cycle: abort wins; no done, no forward.
- Reset mid-operation returns to IDLE immediately; the ibus is reset by the same rst, so no stale responses are expected.

Test Plan:
- start, line=0x0042, gnt always 1, response 2 cycles after grant -> addrs 0x01080,0x01084..0x010BC in order; 16 prefetch_r_valid beats carrying word i data; done pulses with beat 15; busy low next cycle.
- MAX_OUTSTANDING=4, responses withheld -> exactly 4 grants, then req=0 until first mem_r_valid; addr stable across gnt=0 stall cycles.
- Grant and response in the same cycle at outstanding==4 -> counter stays 4; no extra request issued that cycle.
- Abort after 6 grants with 3 outstanding -> req drops that cycle; 3 responses consumed without prefetch_r_valid; IDLE after last; done never pulses.
- start asserted while busy and during FLUSH -> ignored; line address unchanged; a subsequent start in IDLE fetches the new line correctly.
- rst asserted mid-ISSUE -> next cycle all outputs 0, state IDLE; a following start runs a full clean 16-word line.
